gpio_controller: RTL and testbench
==================================

Name: gpio_controller

Overview:
- Memory-mapped 32-bit general-purpose I/O port on the shared CPU memory bus, next to the memory and I/O controllers.
- Decodes a 16-byte register window at base address ADDR.
- Holds output, direction and toggle controls, and drives the bidirectional gpio pins.
- Drives the shared tristate data bus only when one of its registers is read.

Parameters:
- ADDR, 32'h8000_0010, base byte address of the register window. Must be 16-byte aligned.

Ports:
- clk  input  1  bus/memory clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- addr  input  32  bus byte address
- data  inout  32  shared bus data; driven by this block only for a selected read, otherwise high-Z
- rw  input  1  1 = write, 0 = read
- size  input  2  00 byte, 01 halfword, 10 word, 11 reserved
- gpio  inout  32  external pins

Behaviour:
- Select: sel = (addr[31:4] == ADDR[31:4]); offset = addr[3:0].
- Register map (offset, name):
  - 0x0 OUT: read/write output latch.
  - 0x4 DIR: read/write; bit = 1 means the pin is an output.
  - 0x8 IN: read-only pin state; writes are ignored.
  - 0xC TOG: write-only; written 1-bits invert the corresponding OUT bits; reads return 0.
- Access sizes:
  - Word access requires offset[1:0] = 00.
  - Halfword access requires offset[0] = 0.
  - Byte access is allowed at any offset.
  - Misaligned accesses and size = 11: writes are ignored; reads drive 32'h0.
- Little-endian lanes:
  - A byte at offset k accesses register bits [8*(k%4)+7 : 8*(k%4)].
  - A halfword accesses the corresponding 16 bits.
- Write: on the rising clk edge with rst = 0, sel = 1 and rw = 1:
  - The addressed bits are loaded from data[7:0], data[15:0] or data[31:0] according to size.
  - Unaddressed bits are unchanged.
  - A TOG write XORs the selected bits into OUT.
- Read:
  - Combinational. When sel = 1 and rw = 0, data is driven with the addressed field right-justified and zero-extended to 32 bits.
  - Otherwise data is 32'hZZZZ_ZZZZ.
  - There is no read latency: the value is valid in the same cycle the address is presented.
- Pins: gpio[i] = DIR[i] ? OUT[i] : 1'bZ, continuously.
- IN:
  - Reflects the gpio pin levels, so a bit configured as output reads back its driven value.
  - Timing depends on GPIO_INPUT_SYNC_EN.
- Reset:
  - While rst = 1 at the clk edge: OUT = 0, DIR = 0 (all pins high-Z), synchronizer flops = 0.
  - Reset has priority over a simultaneous write.
  - Reset does not gate the combinational read path; reads during reset return the current register values.
- Addresses outside the window have no effect on state and never drive data.

Optional Feature:
- Macro GPIO_INPUT_SYNC_EN.
- Defined:
  - Each gpio bit passes through a 2-flop synchronizer clocked by clk, reset to 0 by rst.
  - IN returns the synchronized value; a pin change is visible on IN after the 2nd rising edge.
- Undefined:
  - IN is the raw gpio value, combinational.
  - No synchronizer flops exist.

Test Plan:
1. Reset, then external gpio = 32'h0000_0021, read word at 0x8000_0018.
   - Sync off: data = 32'h0000_0021 immediately.
   - Sync on: data = 32'h0000_0021 after 2 edges.
   - Before reset, and while rst is held, DIR and OUT read 0.
2. Write DIR (0x8000_0014) = 32'h0000_00FF, then OUT (0x8000_0010) = 32'hA5A5_A5A5.
   - gpio[7:0] = 8'hA5; gpio[31:8] = Z.
   - OUT reads back 32'hA5A5_A5A5.
3. Byte write 8'h3C to 0x8000_0012, then halfword read at 0x8000_0012.
   - OUT = 32'hA53C_A5A5.
   - Halfword read returns 32'h0000_A53C.
4. Word write 32'h0000_000F to TOG (0x8000_001C) with OUT = 32'h0000_00A5.
   - OUT becomes 32'h0000_00AA.
   - TOG reads 0.
5. Misaligned word write at 0x8000_0011, a write to IN, and accesses outside the window (0x8000_0020, 0x8000_000C).
   - All registers are unchanged.
   - data stays Z for the out-of-window reads.
   - The misaligned read returns 32'h0.
6. Assert rst in the same cycle as a write of 32'hFFFF_FFFF to DIR.
   - DIR = 0 afterwards; all gpio pins are Z.

Source files
------------

// File: rtl/gpio_controller.sv
// 32-bit memory-mapped GPIO port with OUT/DIR/IN/TOG registers on a shared tristate bus.
// Define GPIO_INPUT_SYNC_EN to pass the pins through a 2-flop synchronizer before IN.
module gpio_controller #(
    parameter logic [31:0] ADDR = 32'h8000_0010
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    inout  wire  [31:0] data,
    input  logic        rw,
    input  logic [1:0]  size,
    inout  wire  [31:0] gpio
);

    logic [31:0] out_q, out_d;
    logic [31:0] dir_q, dir_d;
    logic [31:0] in_val;

    logic        sel;
    logic [3:0]  off;
    logic [4:0]  shift;
    logic        aligned;
    logic [31:0] lane_mask;
    logic [31:0] mask;
    logic [31:0] wr_field;
    logic        wr_en;
    logic [31:0] rd_reg;
    logic [31:0] rdata;

    assign sel   = (addr[31:4] == ADDR[31:4]);
    assign off   = addr[3:0];
    assign shift = {off[1:0], 3'b000};

    always_comb begin
        aligned   = 1'b0;
        lane_mask = '0;
        case (size)
            2'b00: begin
                aligned   = 1'b1;
                lane_mask = 32'h0000_00FF;
            end
            2'b01: begin
                aligned   = ~off[0];
                lane_mask = 32'h0000_FFFF;
            end
            2'b10: begin
                aligned   = (off[1:0] == 2'b00);
                lane_mask = 32'hFFFF_FFFF;
            end
            default: ;
        endcase
    end

    assign mask     = lane_mask << shift;
    assign wr_field = (data & lane_mask) << shift;
    assign wr_en    = sel & rw & aligned;

    always_comb begin
        out_d = out_q;
        dir_d = dir_q;
        if (wr_en) begin
            case (off[3:2])
                2'd0:    out_d = (out_q & ~mask) | wr_field;
                2'd1:    dir_d = (dir_q & ~mask) | wr_field;
                2'd3:    out_d = out_q ^ wr_field;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
            dir_q <= '0;
        end else begin
            out_q <= out_d;
            dir_q <= dir_d;
        end
    end

    always_comb begin
        case (off[3:2])
            2'd0:    rd_reg = out_q;
            2'd1:    rd_reg = dir_q;
            2'd2:    rd_reg = in_val;
            default: rd_reg = '0;
        endcase
    end

    // Misaligned or reserved-size reads still own the bus but return zero.
    assign rdata = aligned ? ((rd_reg & mask) >> shift) : '0;
    assign data  = (sel && !rw) ? rdata : 32'hZZZZ_ZZZZ;

    for (genvar i = 0; i < 32; i++) begin : g_pin
        assign gpio[i] = dir_q[i] ? out_q[i] : 1'bz;
    end

`ifdef GPIO_INPUT_SYNC_EN
    logic [31:0] sync1_q, sync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= gpio;
            sync2_q <= sync1_q;
        end
    end

    assign in_val = sync2_q;
`else
    assign in_val = gpio;
`endif

endmodule

// File: tb/tb_gpio_controller.sv
// Scoreboard bench for gpio_controller: stimulus queues expectations, a negedge monitor checks them.
module tb_gpio_controller;

    localparam logic [31:0] Base     = 32'h8000_0010;
    localparam logic [31:0] Sentinel = 32'h5A5A_5A5A;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = 32'h0;
    logic        rw = 1'b0;
    logic [1:0]  size = 2'b10;
    logic        tb_drv = 1'b0;
    logic [31:0] tb_data = 32'h0;
    logic [31:0] ext_oe = 32'h0;
    logic [31:0] ext_val = 32'h0;
    wire  [31:0] data;
    wire  [31:0] gpio;

    typedef struct {
        logic [31:0] exp;
        logic [31:0] mask;
        bit          on_gpio;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    bit   mon_en = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    assign data = tb_drv ? tb_data : 32'hZZZZ_ZZZZ;
    for (genvar i = 0; i < 32; i++) begin : g_ext
        assign gpio[i] = ext_oe[i] ? ext_val[i] : 1'bz;
    end

    gpio_controller #(.ADDR(Base)) dut (
        .clk  (clk),
        .rst  (rst),
        .addr (addr),
        .data (data),
        .rw   (rw),
        .size (size),
        .gpio (gpio)
    );

    // Monitor: whenever a response is presented, pop the oldest expectation and compare.
    always @(negedge clk) begin
        if (mon_en) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty: response presented with no expectation queued");
            end else begin
                exp_t        e;
                logic [31:0] got;
                e   = exp_q.pop_front();
                got = e.on_gpio ? gpio : data;
                if ((got & e.mask) !== (e.exp & e.mask)) begin
                    n_fail++;
                    $display("FAIL %s: got %08h required %08h (mask %08h)",
                             e.name, got & e.mask, e.exp & e.mask, e.mask);
                end
            end
        end
    end

    task automatic idle(input int n);
        addr   = 32'h0;
        rw     = 1'b0;
        tb_drv = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        addr    = a;
        size    = sz;
        rw      = 1'b1;
        tb_drv  = 1'b1;
        tb_data = d;
        @(posedge clk);
        #1;
        rw     = 1'b0;
        tb_drv = 1'b0;
        addr   = 32'h0;
    endtask

    task automatic expect_push(input logic [31:0] e, input logic [31:0] m, input bit g,
                               input string nm);
        exp_t x;
        x.exp     = e;
        x.mask    = m;
        x.on_gpio = g;
        x.name    = nm;
        exp_q.push_back(x);
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] e,
                            input string nm);
        addr   = a;
        size   = sz;
        rw     = 1'b0;
        tb_drv = 1'b0;
        expect_push(e, 32'hFFFF_FFFF, 1'b0, nm);
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        addr   = 32'h0;
    endtask

    // Out-of-window read while another bus agent drives a sentinel; any DUT drive disturbs it.
    task automatic foreign_read(input logic [31:0] a, input string nm);
        addr    = a;
        size    = 2'b10;
        rw      = 1'b0;
        tb_drv  = 1'b1;
        tb_data = Sentinel;
        expect_push(Sentinel, 32'hFFFF_FFFF, 1'b0, nm);
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        tb_drv = 1'b0;
        addr   = 32'h0;
    endtask

    task automatic pin_check(input logic [31:0] e, input logic [31:0] m, input string nm);
        expect_push(e, m, 1'b1, nm);
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // 1. Reset and input path
        repeat (2) @(posedge clk);
        #1;
        bus_read(32'h8000_0010, 2'b10, 32'h0, "out_in_reset");
        bus_read(32'h8000_0014, 2'b10, 32'h0, "dir_in_reset");
        rst     = 1'b0;
        ext_oe  = 32'hFFFF_FFFF;
        ext_val = 32'h0000_0021;
`ifdef GPIO_INPUT_SYNC_EN
        bus_read(32'h8000_0018, 2'b10, 32'h0, "in_sync_edge0");
        bus_read(32'h8000_0018, 2'b10, 32'h0, "in_sync_edge1");
`else
        bus_read(32'h8000_0018, 2'b10, 32'h0000_0021, "in_immediate");
        bus_read(32'h8000_0018, 2'b10, 32'h0000_0021, "in_hold");
`endif
        bus_read(32'h8000_0018, 2'b10, 32'h0000_0021, "in_after_2_edges");

        // 2. Direction and output latch
        ext_oe  = 32'hFFFF_FF00;
        ext_val = 32'h1234_5600;
        bus_write(32'h8000_0014, 2'b10, 32'h0000_00FF);
        bus_write(32'h8000_0010, 2'b10, 32'hA5A5_A5A5);
        bus_read(32'h8000_0010, 2'b10, 32'hA5A5_A5A5, "out_word");
        bus_read(32'h8000_0014, 2'b10, 32'h0000_00FF, "dir_word");
        pin_check(32'h0000_00A5, 32'h0000_00FF, "pins_driven");
        idle(2);
        bus_read(32'h8000_0018, 2'b10, 32'h1234_56A5, "in_mixed_pins");

        // 3. Byte write, halfword and byte reads
        bus_write(32'h8000_0012, 2'b00, 32'hFFFF_FF3C);
        bus_read(32'h8000_0010, 2'b10, 32'hA53C_A5A5, "out_after_byte_wr");
        bus_read(32'h8000_0012, 2'b01, 32'h0000_A53C, "half_read_hi");
        bus_read(32'h8000_0013, 2'b00, 32'h0000_00A5, "byte_read_lane3");

        // 4. Toggle register
        bus_write(32'h8000_0010, 2'b10, 32'h0000_00A5);
        bus_write(32'h8000_001C, 2'b10, 32'h0000_000F);
        bus_read(32'h8000_0010, 2'b10, 32'h0000_00AA, "out_after_tog");
        bus_read(32'h8000_001C, 2'b10, 32'h0, "tog_reads_zero");
        pin_check(32'h0000_00AA, 32'h0000_00FF, "pins_after_tog");
        bus_write(32'h8000_001D, 2'b00, 32'h0000_0001);
        bus_read(32'h8000_0010, 2'b10, 32'h0000_01AA, "out_after_byte_tog");

        // 5. Ignored writes and non-driving reads
        bus_write(32'h8000_0011, 2'b10, 32'hFFFF_FFFF);
        bus_write(32'h8000_0013, 2'b01, 32'hFFFF_FFFF);
        bus_write(32'h8000_0010, 2'b11, 32'hFFFF_FFFF);
        bus_write(32'h8000_0018, 2'b10, 32'hFFFF_FFFF);
        bus_write(32'h8000_0020, 2'b10, 32'hFFFF_FFFF);
        bus_write(32'h8000_000C, 2'b10, 32'hFFFF_FFFF);
        bus_read(32'h8000_0010, 2'b10, 32'h0000_01AA, "out_unchanged");
        bus_read(32'h8000_0014, 2'b10, 32'h0000_00FF, "dir_unchanged");
        bus_read(32'h8000_0011, 2'b10, 32'h0, "misaligned_word_read");
        bus_read(32'h8000_0010, 2'b11, 32'h0, "reserved_size_read");
        foreign_read(32'h8000_0020, "no_drive_above");
        foreign_read(32'h8000_000C, "no_drive_below");

        // 6. Reset wins over a simultaneous write
        addr    = 32'h8000_0014;
        size    = 2'b10;
        rw      = 1'b1;
        tb_drv  = 1'b1;
        tb_data = 32'hFFFF_FFFF;
        rst     = 1'b1;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        rw     = 1'b0;
        tb_drv = 1'b0;
        addr   = 32'h0;
        bus_read(32'h8000_0014, 2'b10, 32'h0, "dir_after_reset_wr");
        bus_read(32'h8000_0010, 2'b10, 32'h0, "out_after_reset_wr");
        ext_oe  = 32'hFFFF_FFFF;
        ext_val = 32'hCAFE_F00D;
        idle(2);
        bus_read(32'h8000_0018, 2'b10, 32'hCAFE_F00D, "pins_released");

        idle(2);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
